// File: rtl/instr_fetch.sv
// Instruction fetch unit: program counter plus req/ack read of instruction memory.
// Delivers each fetched instruction with a one-cycle strobe; halt is sticky until RST.
module instr_fetch #(
   parameter int PC_WIDTH    = 8,
   parameter int INSTR_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   RST,
   input  logic                   fetch_en,
   input  logic                   jump,
   input  logic [PC_WIDTH-1:0]    jump_addr,
   input  logic                   halt,
   output logic                   imem_req,
   output logic [PC_WIDTH-1:0]    imem_addr,
   input  logic                   imem_ack,
   input  logic [INSTR_WIDTH-1:0] imem_data,
   output logic [INSTR_WIDTH-1:0] instr,
   output logic                   instr_valid,
   output logic [PC_WIDTH-1:0]    pc,
   output logic                   busy,
   output logic                   halted
);

   typedef enum logic [1:0] {IDLE, REQ, HALT} state_t;

   state_t                 state_q;
   logic [PC_WIDTH-1:0]    pc_q, addr_q, pc_next_d;
   logic [INSTR_WIDTH-1:0] instr_q;
   logic                   req_q, valid_q, busy_q, halted_q, halt_pend_q;

   // The returned instruction came from addr_q, so the successor is addr_q+1 (wraps).
   assign pc_next_d = PC_WIDTH'(addr_q + 1'b1);

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state_q     <= IDLE;
         pc_q        <= '0;
         addr_q      <= '0;
         instr_q     <= '0;
         req_q       <= 1'b0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         halted_q    <= 1'b0;
         halt_pend_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (halt) begin
                  state_q  <= HALT;
                  halted_q <= 1'b1;
               end else if (jump && fetch_en) begin
                  pc_q    <= jump_addr;
                  addr_q  <= jump_addr;
                  req_q   <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= REQ;
               end else if (jump) begin
                  pc_q <= jump_addr;
               end else if (fetch_en) begin
                  addr_q  <= pc_q;
                  req_q   <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= REQ;
               end
            end
            REQ: begin
               if (halt) halt_pend_q <= 1'b1;
               if (imem_ack) begin
                  instr_q     <= imem_data;
                  valid_q     <= 1'b1;
                  req_q       <= 1'b0;
                  busy_q      <= 1'b0;
                  pc_q        <= pc_next_d;
                  halt_pend_q <= 1'b0;
                  // A halt seen at any point in the read takes effect as it completes.
                  if (halt_pend_q || halt) begin
                     state_q  <= HALT;
                     halted_q <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            HALT: begin
               halted_q <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = addr_q;
   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign pc          = pc_q;
   assign busy        = busy_q;
   assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, zero/wait-state fetches, jumps, ignored inputs, halt.
module tb_instr_fetch;

   logic       clk = 1'b0;
   logic       RST;
   logic       fetch_en, jump, halt, imem_ack;
   logic [7:0] jump_addr, imem_data;
   logic       imem_req, instr_valid, busy, halted;
   logic [7:0] imem_addr, instr, pc;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   instr_fetch #(.PC_WIDTH(8), .INSTR_WIDTH(8)) dut (
      .clk(clk), .RST(RST),
      .fetch_en(fetch_en), .jump(jump), .jump_addr(jump_addr), .halt(halt),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_data(imem_data),
      .instr(instr), .instr_valid(instr_valid), .pc(pc),
      .busy(busy), .halted(halted)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one edge; outputs are sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Entered in the first request cycle; waits, then acks with data.
   task automatic run_req(input int waits, input logic [7:0] data,
                          input logic [7:0] exp_addr, input logic [7:0] exp_pc,
                          input string tag);
      check({tag, ".req"},  32'(imem_req), 32'd1);
      check({tag, ".busy"}, 32'(busy), 32'd1);
      check({tag, ".addr"}, 32'(imem_addr), 32'(exp_addr));
      for (int i = 0; i < waits; i++) begin
         imem_ack = 1'b0;
         tick();
         check({tag, ".wreq"},  32'(imem_req), 32'd1);
         check({tag, ".waddr"}, 32'(imem_addr), 32'(exp_addr));
         check({tag, ".wvld"},  32'(instr_valid), 32'd0);
      end
      imem_ack  = 1'b1;
      imem_data = data;
      tick();
      imem_ack = 1'b0;
      check({tag, ".vld"},   32'(instr_valid), 32'd1);
      check({tag, ".instr"}, 32'(instr), 32'(data));
      check({tag, ".pc"},    32'(pc), 32'(exp_pc));
      check({tag, ".reqlo"}, 32'(imem_req), 32'd0);
   endtask

   initial begin
      RST = 1'b1; fetch_en = 0; jump = 0; halt = 0; imem_ack = 0;
      jump_addr = 8'h00; imem_data = 8'h00;
      #1;
      check("rst.req", 32'(imem_req), 32'd0);
      check("rst.pc", 32'(pc), 32'd0);
      check("rst.instr", 32'(instr), 32'd0);
      check("rst.vld", 32'(instr_valid), 32'd0);
      check("rst.busy", 32'(busy), 32'd0);
      check("rst.halted", 32'(halted), 32'd0);
      tick(); tick();
      RST = 1'b0;
      tick();

      // Reset mid-REQ at address 0x05
      jump = 1; jump_addr = 8'h05; fetch_en = 1;
      tick();
      jump = 0; fetch_en = 0;
      check("mid.req", 32'(imem_req), 32'd1);
      check("mid.addr", 32'(imem_addr), 32'h05);
      RST = 1'b1;
      #1;
      check("mid.rreq", 32'(imem_req), 32'd0);
      check("mid.rpc", 32'(pc), 32'd0);
      check("mid.rinstr", 32'(instr), 32'd0);
      check("mid.rvld", 32'(instr_valid), 32'd0);
      tick();
      RST = 1'b0;
      tick();
      check("mid.idle_req", 32'(imem_req), 32'd0);
      check("mid.idle_busy", 32'(busy), 32'd0);

      // Zero-wait fetch at pc=0
      fetch_en = 1;
      tick();
      fetch_en = 0;
      run_req(0, 8'hA3, 8'h00, 8'h01, "zw");
      tick();
      check("zw.vld_off", 32'(instr_valid), 32'd0);
      check("zw.pc_hold", 32'(pc), 32'h01);

      // Three wait cycles, back-to-back fetch requested in the strobe cycle
      fetch_en = 1;
      tick();
      fetch_en = 0;
      run_req(3, 8'h11, 8'h01, 8'h02, "w3a");
      fetch_en = 1;
      tick();
      fetch_en = 0;
      run_req(3, 8'h22, 8'h02, 8'h03, "w3b");
      tick();

      // Jump-only then fetch uses new pc
      jump = 1; jump_addr = 8'h10;
      tick();
      jump = 0;
      check("jo.pc", 32'(pc), 32'h10);
      check("jo.req", 32'(imem_req), 32'd0);
      fetch_en = 1;
      tick();
      fetch_en = 0;
      run_req(0, 8'h33, 8'h10, 8'h11, "jo");
      tick();

      // Jump with fetch to 0xFF, pc wraps
      jump = 1; jump_addr = 8'hFF; fetch_en = 1;
      tick();
      jump = 0; fetch_en = 0;
      run_req(0, 8'h7C, 8'hFF, 8'h00, "wrap");
      tick();

      // Jump during REQ is ignored
      fetch_en = 1;
      tick();
      fetch_en = 0;
      check("jreq.addr0", 32'(imem_addr), 32'h00);
      jump = 1; jump_addr = 8'h40;
      tick();
      jump = 0;
      check("jreq.addr1", 32'(imem_addr), 32'h00);
      run_req(0, 8'h44, 8'h00, 8'h01, "jreq");
      tick();

      // Spurious ack in IDLE
      imem_ack = 1; imem_data = 8'hEE;
      tick();
      imem_ack = 0;
      check("sp.vld", 32'(instr_valid), 32'd0);
      check("sp.instr", 32'(instr), 32'h44);
      check("sp.pc", 32'(pc), 32'h01);
      check("sp.req", 32'(imem_req), 32'd0);

      // Halt pulse during a 2-wait REQ
      fetch_en = 1;
      tick();
      fetch_en = 0;
      check("hr.addr", 32'(imem_addr), 32'h01);
      halt = 1;
      tick();
      halt = 0;
      check("hr.halted_w1", 32'(halted), 32'd0);
      tick();
      check("hr.req_w2", 32'(imem_req), 32'd1);
      imem_ack = 1; imem_data = 8'h5A;
      tick();
      imem_ack = 0;
      check("hr.vld", 32'(instr_valid), 32'd1);
      check("hr.halted", 32'(halted), 32'd1);
      check("hr.instr", 32'(instr), 32'h5A);
      check("hr.pc", 32'(pc), 32'h02);
      fetch_en = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("hr.noreq", 32'(imem_req), 32'd0);
         check("hr.novld", 32'(instr_valid), 32'd0);
         check("hr.stay", 32'(halted), 32'd1);
      end
      fetch_en = 0;
      check("hr.pchold", 32'(pc), 32'h02);
      RST = 1'b1;
      #1;
      check("hr.rst_halted", 32'(halted), 32'd0);
      tick();
      RST = 1'b0;
      tick();

      // Halt sampled in IDLE
      halt = 1;
      tick();
      halt = 0;
      check("hi.halted", 32'(halted), 32'd1);
      check("hi.req", 32'(imem_req), 32'd0);
      fetch_en = 1;
      tick();
      fetch_en = 0;
      check("hi.noreq", 32'(imem_req), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
